// File: rtl/knn_seq_pkg.sv
// Shared definitions for the KNN dataset sequencer: bus widths, KNN register map
// addresses and the sequencer FSM state encoding.
package knn_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 16;
    localparam int KNN_ADDR_W = 6;
    localparam int CNT_W      = 16;

    // KNN register map addresses, kept in step with the peripheral
    localparam int KNN_DATASET_XY_ADDR       = 0;
    localparam int KNN_DATASET_CLASS_ADDR    = 1;
    localparam int KNN_FINISHED_DATASET_ADDR = 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD_XY     = 4'd1,
        ST_WR_XY     = 4'd2,
        ST_RD_CLS    = 4'd3,
        ST_WR_CLS    = 4'd4,
        ST_GAP       = 4'd5,
        ST_FINISH    = 4'd6,
        ST_WAIT_CALC = 4'd7,
        ST_DONE      = 4'd8
    } seq_state_t;

endpackage

// File: rtl/knn_seq_gap_timer.sv
// Loadable down-counter that times the idle window after each class write;
// expired is high on the last cycle of the window.
module knn_seq_gap_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (en && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // A window of N cycles ends on the cycle the count reads 1 (or 0 for N=0)
    assign expired = (cnt_reg <= CNT_W'(1));

endmodule

// File: rtl/knn_dataset_sequencer.sv
// Bus master that streams {y,x}/class entry pairs from memory into the KNN unit,
// then signals end of dataset. Optional irq output enabled by KNN_SEQ_IRQ_EN.
module knn_dataset_sequencer
    import knn_seq_pkg::*;
#(
    parameter int DATA_W      = knn_seq_pkg::DATA_W,
    parameter int MEM_ADDR_W  = knn_seq_pkg::MEM_ADDR_W,
    parameter int KNN_ADDR_W  = knn_seq_pkg::KNN_ADDR_W,
    parameter int CNT_W       = knn_seq_pkg::CNT_W,
    parameter int GAP_CYCLES  = 2,
    parameter int XY_ADDR     = KNN_DATASET_XY_ADDR,
    parameter int CLASS_ADDR  = KNN_DATASET_CLASS_ADDR,
    parameter int FINISH_ADDR = KNN_FINISHED_DATASET_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_valid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  knn_valid,
    output logic [KNN_ADDR_W-1:0] knn_address,
    output logic [DATA_W-1:0]     knn_wdata,
    output logic                  knn_wstrb,
    input  logic                  knn_ready,
`ifdef KNN_SEQ_IRQ_EN
    output logic                  irq,
`endif
    input  logic                  knn_calc
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             gap_load;
    logic             gap_en;
    logic             gap_expired;

    assign gap_load  = (state_reg == ST_WR_CLS) && knn_valid && knn_ready;
    assign gap_en    = (state_reg == ST_GAP);
    assign knn_wstrb = knn_valid;

    knn_seq_gap_timer #(
        .CNT_W(GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_W'(GAP_CYCLES)),
        .en         (gap_en),
        .expired    (gap_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_valid     <= 1'b0;
            mem_addr      <= '0;
            knn_valid     <= 1'b0;
            knn_address   <= '0;
            knn_wdata     <= '0;
`ifdef KNN_SEQ_IRQ_EN
            irq           <= 1'b0;
`endif
        end else begin
`ifdef KNN_SEQ_IRQ_EN
            irq <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mem_addr      <= base_addr;
                        remaining_reg <= count;
                        if (count == '0) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
`ifdef KNN_SEQ_IRQ_EN
                            irq       <= 1'b1;
`endif
                        end else begin
                            state_reg <= ST_RD_XY;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            mem_valid <= 1'b1;
                        end
                    end
                end
                ST_RD_XY, ST_RD_CLS: begin
                    // Read data goes straight into the write data register, held until accepted
                    if (mem_valid && mem_ready) begin
                        mem_valid   <= 1'b0;
                        mem_addr    <= mem_addr + 1'b1;
                        knn_valid   <= 1'b1;
                        knn_wdata   <= mem_rdata;
                        knn_address <= (state_reg == ST_RD_XY) ? KNN_ADDR_W'(XY_ADDR)
                                                               : KNN_ADDR_W'(CLASS_ADDR);
                        state_reg   <= (state_reg == ST_RD_XY) ? ST_WR_XY : ST_WR_CLS;
                    end
                end
                ST_WR_XY: begin
                    if (knn_valid && knn_ready) begin
                        knn_valid <= 1'b0;
                        mem_valid <= 1'b1;
                        state_reg <= ST_RD_CLS;
                    end
                end
                ST_WR_CLS: begin
                    if (knn_valid && knn_ready) begin
                        knn_valid     <= 1'b0;
                        remaining_reg <= remaining_reg - 1'b1;
                        state_reg     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_expired) begin
                        if (remaining_reg != '0) begin
                            mem_valid <= 1'b1;
                            state_reg <= ST_RD_XY;
                        end else begin
                            knn_valid   <= 1'b1;
                            knn_address <= KNN_ADDR_W'(FINISH_ADDR);
                            knn_wdata   <= '0;
                            state_reg   <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    if (knn_valid && knn_ready) begin
                        knn_valid <= 1'b0;
                        state_reg <= ST_WAIT_CALC;
                    end
                end
                ST_WAIT_CALC: begin
                    if (!knn_calc) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
`ifdef KNN_SEQ_IRQ_EN
                        irq       <= 1'b1;
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
